// File: rtl/sram_arbiter.sv
// sram_arbiter: 2:1 arbiter between instruction fetch and data memory onto a
// single SRAM-like port. One outstanding transaction; data wins by default.
// Optional fetch anti-starvation counter: define ARB_INST_NOSTARVE_EN.
module sram_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 2;
  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t          state, state_n;
  logic            owner, owner_n;       // 0 = inst, 1 = data
  logic            m_req_n, m_wr_n;
  logic [SW-1:0]   m_size_n;
  logic [AW-1:0]   m_addr_n;
  logic [DW-1:0]   m_wdata_n;
  logic            starved;
  logic            grant_inst, grant_data;

`ifdef ARB_INST_NOSTARVE_EN
  logic [CW-1:0]   starve_cnt, starve_cnt_n;

  // Fetch has waited through the maximum run of data grants
  assign starved = (starve_cnt == CW'(STARVE_MAX));
`else
  logic            unused_starve_max;

  // Strict data priority; the starvation limit has no effect in this build
  assign starved           = 1'b0;
  assign unused_starve_max = ^(32'(STARVE_MAX));
`endif

  // Grant selection evaluated while idle
  assign grant_inst = inst_req & (~data_req | starved);
  assign grant_data = data_req & ~grant_inst;

  // Handshake and read-data return toward the current owner
  assign inst_addr_ok = (state == ADDR) & m_addr_ok & ~owner;
  assign data_addr_ok = (state == ADDR) & m_addr_ok &  owner;
  assign inst_data_ok = (state == DATA) & m_data_ok & ~owner;
  assign data_data_ok = (state == DATA) & m_data_ok &  owner;
  assign inst_rdata   = m_rdata;
  assign data_rdata   = m_rdata;

  // Next-state, latched request fields and starvation count
  always_comb begin
    state_n   = state;
    owner_n   = owner;
    m_req_n   = m_req;
    m_wr_n    = m_wr;
    m_size_n  = m_size;
    m_addr_n  = m_addr;
    m_wdata_n = m_wdata;
`ifdef ARB_INST_NOSTARVE_EN
    starve_cnt_n = starve_cnt;
`endif
    case (state)
      IDLE: begin
        if (grant_inst || grant_data) begin
          state_n = ADDR;
          m_req_n = 1'b1;
          owner_n = grant_data;
          if (grant_data) begin
            m_wr_n    = data_wr;
            m_size_n  = data_size;
            m_addr_n  = data_addr;
            m_wdata_n = data_wdata;
          end else begin
            m_wr_n    = 1'b0;
            m_size_n  = SW'(2);
            m_addr_n  = inst_addr;
            m_wdata_n = '0;
          end
`ifdef ARB_INST_NOSTARVE_EN
          if (grant_inst) begin
            starve_cnt_n = '0;
          end else if (inst_req && !starved) begin
            starve_cnt_n = starve_cnt + CW'(1);
          end
`endif
        end
      end
      ADDR: begin
        if (m_addr_ok) begin
          m_req_n = 1'b0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (m_data_ok) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        m_req_n = 1'b0;
      end
    endcase
  end

  // State and registered shared-port outputs
  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state   <= IDLE;
      owner   <= 1'b0;
      m_req   <= 1'b0;
      m_wr    <= 1'b0;
      m_size  <= '0;
      m_addr  <= '0;
      m_wdata <= '0;
`ifdef ARB_INST_NOSTARVE_EN
      starve_cnt <= '0;
`endif
    end else begin
      state   <= state_n;
      owner   <= owner_n;
      m_req   <= m_req_n;
      m_wr    <= m_wr_n;
      m_size  <= m_size_n;
      m_addr  <= m_addr_n;
      m_wdata <= m_wdata_n;
`ifdef ARB_INST_NOSTARVE_EN
      starve_cnt <= starve_cnt_n;
`endif
    end
  end

endmodule
